ir_command_hold: RTL and testbench

- Upstream stage of the seven-segment command display state machine.
- Accepts validated command bytes from the IR receiver/decoder and checks them for legality.
- Converts each legal byte into the 4-bit command vector {FWD, BACK, LEFT, RIGHT} that the display and motor stages consume.
- Holds each command for a programmable time, then drops it; also generates the display refresh enable tick.

---
 rtl/ir_cmd_pkg.sv | 41 ++++
 rtl/tick_divider.sv | 32 +++
 rtl/ir_command_hold.sv | 88 ++++++++
 tb/tb_ir_command_hold.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ir_cmd_pkg.sv
// Shared definitions for the IR command path: command bit positions, the STOP code,
// FSM state encodings and the byte classifier used by the hold stage.
package ir_cmd_pkg;

    localparam int CMD_RIGHT = 0;
    localparam int CMD_LEFT  = 1;
    localparam int CMD_BACK  = 2;
    localparam int CMD_FWD   = 3;

    localparam logic [3:0] STOP_NIBBLE = 4'h0;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } hold_state_t;

    typedef enum logic [1:0] {
        BYTE_NONE    = 2'd0,
        BYTE_LEGAL   = 2'd1,
        BYTE_STOP    = 2'd2,
        BYTE_ILLEGAL = 2'd3
    } byte_kind_t;

    // Opposing directions in the same byte are treated as corrupt, not as STOP.
    function automatic byte_kind_t classify_byte(input logic       valid,
                                                 input logic [7:0] code,
                                                 input logic [3:0] prefix);
        if (!valid)
            return BYTE_NONE;
        if (code[7:4] != prefix)
            return BYTE_ILLEGAL;
        if (code[CMD_RIGHT] && code[CMD_LEFT])
            return BYTE_ILLEGAL;
        if (code[CMD_BACK] && code[CMD_FWD])
            return BYTE_ILLEGAL;
        if (code[3:0] == STOP_NIBBLE)
            return BYTE_STOP;
        return BYTE_LEGAL;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider: TICK is a one-cycle pulse every TICK_DIV cycles,
// first pulse TICK_DIV cycles after reset release.
module tick_divider #(
    parameter int TICK_DIV = 100_000
) (
    input  logic CLK,
    input  logic RESET,
    output logic TICK
);

    localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             tick_reg;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else begin
            tick_reg <= (cnt_reg == CNT_LAST);
            if (cnt_reg == CNT_LAST)
                cnt_reg <= '0;
            else
                cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign TICK = tick_reg;

endmodule

// File: rtl/ir_command_hold.sv
// Validates IR command bytes, holds the decoded {FWD,BACK,LEFT,RIGHT} vector for
// HOLD_CYCLES after the last legal byte, and provides the display refresh tick.
module ir_command_hold
    import ir_cmd_pkg::*;
#(
    parameter int         HOLD_CYCLES = 50_000_000,
    parameter int         TICK_DIV    = 100_000,
    parameter logic [3:0] CODE_PREFIX = 4'hA
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CMD_VALID,
    input  logic [7:0] CMD_CODE,
    output logic [3:0] COMMAND,
    output logic       CMD_ACTIVE,
    output logic       CMD_REJECT,
    output logic       DISP_TICK
);

    localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    hold_state_t       state_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic [3:0]        command_reg;
    logic              active_reg;
    logic              reject_reg;
    byte_kind_t        byte_kind;

    always_comb begin
        byte_kind = classify_byte(CMD_VALID, CMD_CODE, CODE_PREFIX);
    end

    // A legal byte is checked before expiry so a retrigger on the last count never gaps.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= '0;
            command_reg  <= 4'h0;
            active_reg   <= 1'b0;
            reject_reg   <= 1'b0;
        end else begin
            reject_reg <= (byte_kind == BYTE_ILLEGAL);
            case (state_reg)
                IDLE: begin
                    if (byte_kind == BYTE_LEGAL) begin
                        state_reg    <= HOLD;
                        command_reg  <= CMD_CODE[3:0];
                        active_reg   <= 1'b1;
                        hold_cnt_reg <= HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (byte_kind == BYTE_LEGAL) begin
                        command_reg  <= CMD_CODE[3:0];
                        hold_cnt_reg <= HOLD_LOAD;
                    end else if (byte_kind == BYTE_STOP || hold_cnt_reg == '0) begin
                        state_reg    <= IDLE;
                        command_reg  <= 4'h0;
                        active_reg   <= 1'b0;
                        hold_cnt_reg <= '0;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg - HOLD_W'(1);
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    command_reg  <= 4'h0;
                    active_reg   <= 1'b0;
                    hold_cnt_reg <= '0;
                end
            endcase
        end
    end

    tick_divider #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_divider (
        .CLK  (CLK),
        .RESET(RESET),
        .TICK (DISP_TICK)
    );

    assign COMMAND    = command_reg;
    assign CMD_ACTIVE = active_reg;
    assign CMD_REJECT = reject_reg;

endmodule

// File: tb/tb_ir_command_hold.sv
// Scoreboard bench for ir_command_hold: stimulus pushes per-cycle expectations from a
// cycle-count reference model; an independent monitor pops and compares after each edge.
module tb_ir_command_hold;

    localparam int         HOLD_CYCLES = 10;
    localparam int         TICK_DIV    = 4;
    localparam logic [3:0] CODE_PREFIX = 4'hA;

    logic       CLK       = 1'b0;
    logic       RESET     = 1'b0;
    logic       CMD_VALID = 1'b0;
    logic [7:0] CMD_CODE  = 8'h00;
    logic [3:0] COMMAND;
    logic       CMD_ACTIVE;
    logic       CMD_REJECT;
    logic       DISP_TICK;

    typedef struct packed {
        logic [3:0] command;
        logic       active;
        logic       reject;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: cycles of hold left (0 = idle), held vector, edges since release.
    int         m_remaining = 0;
    logic [3:0] m_cmd       = 4'h0;
    int         m_edges     = 0;

    always #5 CLK = ~CLK;

    ir_command_hold #(
        .HOLD_CYCLES(HOLD_CYCLES),
        .TICK_DIV   (TICK_DIV),
        .CODE_PREFIX(CODE_PREFIX)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CMD_VALID (CMD_VALID),
        .CMD_CODE  (CMD_CODE),
        .COMMAND   (COMMAND),
        .CMD_ACTIVE(CMD_ACTIVE),
        .CMD_REJECT(CMD_REJECT),
        .DISP_TICK (DISP_TICK)
    );

    // Drive one cycle's inputs (called just after a falling edge) and predict the next edge.
    task automatic drive_cycle(input logic valid, input logic [7:0] code);
        logic [3:0] lo;
        logic       illegal;
        logic       stop;
        exp_t       e;
        CMD_VALID = valid;
        CMD_CODE  = code;
        lo        = code[3:0];
        illegal   = (code[7:4] != CODE_PREFIX) || (lo[0] && lo[1]) || (lo[2] && lo[3]);
        stop      = !illegal && (lo == 4'h0);
        m_edges++;
        if (valid && !illegal && !stop) begin
            m_cmd       = lo;
            m_remaining = HOLD_CYCLES;
        end else if (valid && stop) begin
            m_remaining = 0;
        end else if (m_remaining > 0) begin
            m_remaining--;
        end
        e.command = (m_remaining > 0) ? m_cmd : 4'h0;
        e.active  = (m_remaining > 0);
        e.reject  = valid && illegal;
        e.tick    = (m_edges % TICK_DIV) == 0;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic valid, input logic [7:0] code);
        @(negedge CLK);
        drive_cycle(valid, code);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            send(1'b0, 8'($urandom));
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({COMMAND, CMD_ACTIVE, CMD_REJECT, DISP_TICK} !== 7'b0) begin
            errors++;
            $display("FAIL %s: got cmd=%b act=%b rej=%b tick=%b, want all 0",
                     name, COMMAND, CMD_ACTIVE, CMD_REJECT, DISP_TICK);
        end else begin
            $display("check %s: outputs cleared", name);
        end
    endtask

    task automatic release_reset();
        @(negedge CLK);
        RESET       = 1'b1;
        m_remaining = 0;
        m_edges     = 0;
        drive_cycle(1'b0, 8'h00);
    endtask

    // Async reset between edges: outputs must clear without waiting for a clock edge.
    task automatic async_reset(input int held);
        @(posedge CLK);
        #3;
        RESET = 1'b0;
        #1;
        check_zero("async_reset_immediate");
        for (int i = 0; i < held; i++) begin
            @(negedge CLK);
            CMD_VALID = 1'b1;
            CMD_CODE  = 8'hA5;
        end
        @(posedge CLK);
        #1;
        check_zero("reset_ignores_valid");
        release_reset();
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({COMMAND, CMD_ACTIVE, CMD_REJECT, DISP_TICK} !== e) begin
                    errors++;
                    $display("FAIL cycle_out t=%0t: got cmd=%b act=%b rej=%b tick=%b, want cmd=%b act=%b rej=%b tick=%b",
                             $time, COMMAND, CMD_ACTIVE, CMD_REJECT, DISP_TICK,
                             e.command, e.active, e.reject, e.tick);
                end else begin
                    $display("t=%0t in=%b/%h cmd=%b act=%b rej=%b tick=%b ok",
                             $time, CMD_VALID, CMD_CODE, COMMAND, CMD_ACTIVE, CMD_REJECT, DISP_TICK);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] code;
        #1;
        check_zero("reset_state");
        repeat (3) @(posedge CLK);
        release_reset();

        // 1: idle, tick cadence
        idle(13);
        // 2: single byte, full hold
        send(1'b1, 8'hA1); idle(13);
        // 3: retrigger at cycle 6, then retrigger exactly at the expiry cycle
        send(1'b1, 8'hA9); idle(5); send(1'b1, 8'hA2); idle(12);
        send(1'b1, 8'hA6); idle(9); send(1'b1, 8'hA5); idle(12);
        // 4: illegal bytes in idle and during a hold
        send(1'b1, 8'hB1); send(1'b1, 8'hA3); send(1'b1, 8'hAC); idle(2);
        send(1'b1, 8'hA4); send(1'b1, 8'hB1); send(1'b1, 8'hA3); send(1'b1, 8'hAC); idle(10);
        // 5: stop during hold, stop in idle
        send(1'b1, 8'hA8); idle(2); send(1'b1, 8'hA0); idle(3);
        send(1'b1, 8'hA0); idle(2);
        // 6: reset mid-hold
        send(1'b1, 8'hA5); idle(3);
        async_reset(2);
        idle(9);

        // Randomized traffic, biased toward the legal prefix
        for (int i = 0; i < 600; i++) begin
            code = 8'($urandom);
            if ($urandom_range(0, 9) < 8)
                code[7:4] = CODE_PREFIX;
            if ($urandom_range(0, 19) == 0)
                code = 8'hA0;
            send($urandom_range(0, 9) < 3, code);
            if (i == 300)
                async_reset(1);
        end
        idle(12);

        @(negedge CLK);
        CMD_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
